lif_neuron_layer: RTL and testbench

- Layer of NUM_NODES leaky integrate-and-fire neurons; each integrates a signed input current once per timestep and emits a one-cycle spike when its membrane potential crosses threshold.
- Sits directly upstream of the winner-selection stage: spikes_o drives its nodes_i bus bit-for-bit.
- Timestep advance is strobed by step_i, so the layer can run slower than the clock.
- inhibit_i is a global lateral-inhibition clear.

---
 rtl/lif_neuron_layer.sv | 122 ++++++++++++
 tb/tb_lif_neuron_layer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_layer.sv
// -----------------------------------------------------------------------------
// lif_neuron_layer
//
// A layer of NUM_NODES independent leaky integrate-and-fire neurons. On every
// timestep (step_i strobe) each neuron leaks its membrane potential by
// v >>> LEAK_SHIFT, adds its signed input current and saturates the result.
// If the potential reaches THRESHOLD, the neuron emits a one-cycle spike and
// reloads V_RESET. It then stays silent for REFRAC_STEPS timesteps.
// inhibit_i clears every potential on a step. spikes_o feeds the nodes_i bus
// of the winner-selection stage bit-for-bit.
//
// Ports:
//   clk_i      in   1                    clock, rising edge
//   rst_ni     in   1                    async reset, active-low
//   step_i     in   1                    advance one timestep this cycle
//   current_i  in   NUM_NODES*I_WIDTH    packed signed currents, neuron k at
//                                        [k*I_WIDTH +: I_WIDTH]
//   inhibit_i  in   1                    global clear, qualified by step_i
//   spikes_o   out  NUM_NODES            registered one-cycle spike pulses
//   vmem_o     out  NUM_NODES*V_WIDTH    packed registered membrane potentials
//
// Strobe semantics: there is no ready/backpressure. A timestep is consumed on
// every rising edge where step_i=1. current_i and inhibit_i are sampled only
// on that edge. The results (spikes_o, vmem_o) are visible from the same edge
// and remain until the next edge. spikes_o is forced low on edges without a
// step.
// -----------------------------------------------------------------------------
module lif_neuron_layer #(
  parameter int NUM_NODES    = 1,
  parameter int V_WIDTH      = 16,
  parameter int I_WIDTH      = 8,
  parameter int THRESHOLD    = 1000,
  parameter int LEAK_SHIFT   = 4,
  parameter int REFRAC_STEPS = 2,
  parameter int V_RESET      = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           step_i,
  input  logic [NUM_NODES*I_WIDTH-1:0]   current_i,
  input  logic                           inhibit_i,
  output logic [NUM_NODES-1:0]           spikes_o,
  output logic [NUM_NODES*V_WIDTH-1:0]   vmem_o
);

  // Refractory counter is at least one bit wide so REFRAC_STEPS=0 still
  // yields a legal (always-zero) counter.
  localparam int RC_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRAC_STEPS);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);

  localparam logic signed [V_WIDTH-1:0] V_RST = V_WIDTH'(V_RESET);
  localparam logic signed [V_WIDTH-1:0] THR_V = V_WIDTH'(THRESHOLD);

  // Saturation bounds, expressed both in the wide sum domain and in V_WIDTH.
  localparam logic signed [V_WIDTH+1:0] SUM_MAX = {3'b000, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [V_WIDTH+1:0] SUM_MIN = {3'b111, {(V_WIDTH-1){1'b0}}};
  localparam logic signed [V_WIDTH-1:0] V_MAX   = {1'b0, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [V_WIDTH-1:0] V_MIN   = {1'b1, {(V_WIDTH-1){1'b0}}};

  for (genvar k = 0; k < NUM_NODES; k++) begin : g_node
    logic signed [V_WIDTH-1:0]   v_q, v_d;
    logic        [RC_W-1:0]      rc_q, rc_d;
    logic                        spike_q, spike_d;
    logic signed [I_WIDTH-1:0]   cur;
    logic signed [V_WIDTH+1:0]   sum;
    logic signed [V_WIDTH-1:0]   vn;

    assign cur = current_i[k*I_WIDTH +: I_WIDTH];

    // Two guard bits hold v - leak + current without overflow. The casts
    // keep the operands signed, so each one is sign-extended.
    always_comb begin
      sum = (V_WIDTH+2)'(v_q) - (V_WIDTH+2)'(v_q >>> LEAK_SHIFT)
          + (V_WIDTH+2)'(cur);
      if (sum > SUM_MAX) begin
        vn = V_MAX;
      end else if (sum < SUM_MIN) begin
        vn = V_MIN;
      end else begin
        vn = sum[V_WIDTH-1:0];
      end
    end

    always_comb begin
      v_d     = v_q;
      rc_d    = rc_q;
      spike_d = 1'b0;
      if (step_i) begin
        // Refractory time elapses on every step, inhibited or not.
        if (rc_q != '0) begin
          rc_d = rc_q - RC_ONE;
        end
        if (inhibit_i || (rc_q != '0)) begin
          v_d = V_RST;
        end else if (vn >= THR_V) begin
          spike_d = 1'b1;
          v_d     = V_RST;
          rc_d    = RC_LOAD;
        end else begin
          v_d = vn;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v_q     <= V_RST;
        rc_q    <= '0;
        spike_q <= 1'b0;
      end else begin
        v_q     <= v_d;
        rc_q    <= rc_d;
        spike_q <= spike_d;
      end
    end

    assign spikes_o[k]                   = spike_q;
    assign vmem_o[k*V_WIDTH +: V_WIDTH]  = v_q;
  end

endmodule

// File: tb/tb_lif_neuron_layer.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron_layer
//
// Four neurons with an 8-bit potential, threshold 100, leak shift 4 and
// refractory period 2. An integer reference model of the neuron equations
// predicts {spikes, vmem} for every driven cycle. The prediction goes into
// exp_q and is popped and compared after the clock edge. Fixed-value checks
// pin the known traces: 30/59/86/spike, refractory, saturation at -128,
// inhibit, and async reset.
// -----------------------------------------------------------------------------
module tb_lif_neuron_layer;
  localparam int N   = 4;
  localparam int VW  = 8;
  localparam int IW  = 8;
  localparam int THR = 100;
  localparam int LS  = 4;
  localparam int RS  = 2;
  localparam int VR  = 0;
  localparam int W   = N + N*VW;

  // ---------------- clock / reset ----------------
  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              step_i = 1'b0;
  logic              inhibit_i = 1'b0;
  logic [N*IW-1:0]   current_i = '0;
  logic [N-1:0]      spikes_o;
  logic [N*VW-1:0]   vmem_o;

  always #5 clk_i = ~clk_i;

  lif_neuron_layer #(
    .NUM_NODES(N), .V_WIDTH(VW), .I_WIDTH(IW), .THRESHOLD(THR),
    .LEAK_SHIFT(LS), .REFRAC_STEPS(RS), .V_RESET(VR)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .step_i(step_i), .current_i(current_i),
    .inhibit_i(inhibit_i), .spikes_o(spikes_o), .vmem_o(vmem_o)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           m_v[N];
  int           m_rc[N];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] vm(input int k);
    logic signed [VW-1:0] v;
    v = vmem_o[k*VW +: VW];
    return 64'(v);
  endfunction

  function automatic logic [63:0] sx(input int x);
    return 64'(x);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_v[k]  = VR;
      m_rc[k] = 0;
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle and pushes the model's prediction. After the edge it
  // pops the prediction and compares it against the DUT.
  task automatic drive_cycle(input bit step, input bit inh, input int cur[N]);
    logic [N-1:0]    sp;
    logic [N*VW-1:0] vv;
    logic [W-1:0]    exp;
    int              s;
    step_i    = step;
    inhibit_i = inh;
    for (int k = 0; k < N; k++) begin
      current_i[k*IW +: IW] = IW'(cur[k]);
    end
    sp = '0;
    for (int k = 0; k < N; k++) begin
      if (step) begin
        if (inh) begin
          m_v[k] = VR;
          if (m_rc[k] > 0) m_rc[k]--;
        end else if (m_rc[k] > 0) begin
          m_rc[k]--;
          m_v[k] = VR;
        end else begin
          s = m_v[k] - (m_v[k] >>> LS) + cur[k];
          if (s > 127)  s = 127;
          if (s < -128) s = -128;
          if (s >= THR) begin
            sp[k]   = 1'b1;
            m_v[k]  = VR;
            m_rc[k] = RS;
          end else begin
            m_v[k] = s;
          end
        end
      end
      vv[k*VW +: VW] = VW'(m_v[k]);
    end
    exp_q.push_back({sp, vv});
    @(posedge clk_i);
    #1;
    exp = exp_q.pop_front();
    check("sb_spikes", 64'(spikes_o), 64'(exp[W-1 -: N]));
    check("sb_vmem",   64'(vmem_o),   64'(exp[N*VW-1:0]));
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    step_i = 1'b0;
    inhibit_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    check("rst_vmem",   64'(vmem_o),   64'(0));
    check("rst_spikes", 64'(spikes_o), 64'(0));
    rst_ni = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int cur[N];
  int exp_v0[10]  = '{30, 59, 86, 0, 0, 0, 30, 59, 86, 0};
  int exp_sp0[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
  int exp_v1[3]   = '{-100, -128, -128};
  int held;

  initial begin
    model_reset();
    #2;
    apply_reset();

    // Integrate, fire, refractory, gated idle cycles, negative saturation.
    for (int st = 0; st < 10; st++) begin
      cur[0] = 30;
      cur[1] = -100;
      cur[2] = $urandom_range(0, 40);
      cur[3] = $urandom_range(0, 255) - 128;
      drive_cycle(1'b1, 1'b0, cur);
      check($sformatf("n0_vmem_step%0d", st + 1), vm(0), sx(exp_v0[st]));
      check($sformatf("n0_spike_step%0d", st + 1), 64'(spikes_o[0]),
            64'(exp_sp0[st]));
      if (st < 3) check($sformatf("n1_sat_step%0d", st + 1), vm(1), sx(exp_v1[st]));
      if (st == 3 || st == 7) begin
        held = m_v[0];
        for (int i = 0; i < 5; i++) begin
          for (int k = 0; k < N; k++) cur[k] = $urandom_range(0, 255) - 128;
          drive_cycle(1'b0, 1'($urandom_range(0, 1)), cur);
          check("idle_spikes", 64'(spikes_o), 64'(0));
          check("idle_n0_vmem", vm(0), sx(held));
        end
      end
    end
    check("n1_sat_hold", vm(1), sx(-128));

    // Inhibit: neuron 3 fires, then an inhibited step still counts down its
    // refractory period.
    apply_reset();
    cur = '{90, 90, 90, 127};
    drive_cycle(1'b1, 1'b0, cur);
    check("pre_inh_spikes", 64'(spikes_o), 64'(4'b1000));
    cur = '{127, 127, 127, 127};
    drive_cycle(1'b1, 1'b1, cur);
    check("inh_spikes", 64'(spikes_o), 64'(0));
    check("inh_vmem", 64'(vmem_o), 64'(0));
    drive_cycle(1'b1, 1'b0, cur);
    check("post_inh_spikes", 64'(spikes_o), 64'(4'b0111));
    cur = '{30, 30, 30, 30};
    drive_cycle(1'b1, 1'b0, cur);
    check("inh_refrac_n3", vm(3), sx(30));

    // Random mix of steps, idles and inhibits.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < N; k++) cur[k] = $urandom_range(0, 255) - 128;
      if (i % 3 == 0) cur[0] = $urandom_range(20, 127);
      drive_cycle(1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 9) == 0), cur);
    end

    // Async reset between edges while neuron 0 sits at 86.
    apply_reset();
    cur = '{30, 0, 0, 0};
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, cur);
    check("pre_arst_n0", vm(0), sx(86));
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("arst_vmem", 64'(vmem_o), 64'(0));
    check("arst_spikes", 64'(spikes_o), 64'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive_cycle(1'b1, 1'b0, cur);
    check("post_arst_n0", vm(0), sx(30));

    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
